// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data memory.
// Each granted access is latched, driven onto dmem for one cycle, then acknowledged.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   owner;
  logic   l_lock;
  logic   lock_held;
  logic   lock_own;
  logic   prio;
  logic   grant_vld;
  logic   grant_id;

  // A held lock restricts the grant to its owner; otherwise round-robin on prio.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = prio;
    if (lock_held) begin
      grant_id  = lock_own;
      grant_vld = lock_own ? req1 : req0;
    end else if (req0 && req1) begin
      grant_id  = prio;
      grant_vld = 1'b1;
    end else if (req0) begin
      grant_id  = 1'b0;
      grant_vld = 1'b1;
    end else if (req1) begin
      grant_id  = 1'b1;
      grant_vld = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // mem_a/mem_wd double as the latched address and write-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      l_lock    <= 1'b0;
      lock_held <= 1'b0;
      lock_own  <= 1'b0;
      prio      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rd0       <= '0;
      rd1       <= '0;
      mem_a     <= '0;
      mem_wd    <= '0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state  <= ACCESS;
            owner  <= grant_id;
            mem_a  <= grant_id ? addr1 : addr0;
            mem_wd <= grant_id ? wd1   : wd0;
            mem_we <= grant_id ? we1   : we0;
            l_lock <= grant_id ? lock1 : lock0;
            if (!lock_held) prio <= ~grant_id;
          end
        end
        ACCESS: begin
          state  <= RESP;
          mem_we <= 1'b0;
          if (owner) begin
            rd1  <= mem_rd;
            ack1 <= 1'b1;
          end else begin
            rd0  <= mem_rd;
            ack0 <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          lock_held <= l_lock;
          lock_own  <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer that shares the single-port data memory (`dmem`: combinational read, write on rising clock edge) between the CPU load/store path (port 0) and the host loader/debug port (port 1). Each access is latched, driven onto the memory for one cycle, then acknowledged. Ports are served round-robin, and an optional lock lets one port perform uninterrupted read-modify-write sequences. The block sits between both requesters and the `dmem` instance; nothing else drives `dmem`'s `a`/`wd`/`we`.

## Interface
- `DATA_W`, 32, data width; matches `` `DATA_W `` of `dmem`.
- `ADDR_W`, 16, word address width; matches `dmem` port `a`.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: access request, held high with the fields below stable until the matching ack.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in ADDR_W: word address.
- `wd0` / `wd1` in DATA_W: write data.
- `lock0` / `lock1` in 1: sampled with the request; 1 = keep ownership after this access.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rd0` / `rd1` out DATA_W: registered read data; holds until the next ack to that port.
- `busy` out 1: high when state ≠ IDLE.
- `mem_a` out ADDR_W: to `dmem.a`.
- `mem_wd` out DATA_W: to `dmem.wd`.
- `mem_we` out 1: to `dmem.we`.
- `mem_rd` in DATA_W: from `dmem.rd`.

## Operation
- FSM states: IDLE, ACCESS, RESP. Transitions are IDLE→ACCESS when a request is granted, ACCESS→RESP unconditionally, and RESP→IDLE unconditionally.
- IDLE grant rule:
  - If a lock is held, only the lock owner may be granted. The other port waits even if requesting.
  - Otherwise, with one requester, grant it.
  - With both requesting, grant the port indicated by the priority pointer `prio`.
- On grant:
  - Latch `addr`, `we`, `wd`, `lock` and the owner id into internal registers.
  - Set `prio` to the other port. `prio` does not change while a lock is held.
- ACCESS:
  - `mem_a` = latched addr; `mem_wd` = latched wd; `mem_we` = latched we. All are decoded from registers.
  - `mem_rd` is captured into the owner's `rd` register on the ACCESS→RESP edge, for reads and for writes.
  - For a write, `rd` returns the pre-write contents, since the write commits on the same edge.
- RESP:
  - The owner's ack is high for exactly this cycle.
  - The lock register is updated from the latched lock bit. If 1, owner = lock holder; if 0, lock released.
- Requester protocol: deassert `req` (or present the next request) at the rising edge that ends RESP. A `req` still high in the following IDLE is treated as a new access.
- Outside ACCESS, `mem_we` = 0 and `mem_a` / `mem_wd` hold their last latched values. They are don't-care for `dmem` but must be stable.
- Addresses pass unmodified. No range check is performed, and `dmem` depth is not known to this block.
- A lock holder that stops requesting keeps the lock indefinitely. Release occurs only through an access with `lock` = 0, or through `rst`.

## Timing
- Latency from `req` sampled high in IDLE to `ack` is 2 cycles: ack is high in cycle N+2 when the grant edge ends cycle N. Maximum throughput is one access per 3 cycles.
- A write is visible to a `dmem` read from the next cycle after ACCESS, i.e. in RESP.
- Values at reset:
  - state = IDLE
  - `ack0` = `ack1` = 0
  - `rd0` = `rd1` = 0
  - `mem_we` = 0
  - `mem_a` = 0, `mem_wd` = 0
  - `prio` = port 0
  - lock released
  - `busy` = 0
- Reset in ACCESS: a pending write still commits at the edge where `rst` is sampled, because `mem_we` is already high during that cycle. No ack is issued afterwards.
- Reset in RESP: the ack visible in that cycle stands. The lock is cleared.
- Simultaneous requests with no lock: service alternates, 0,1,0,1… starting from port 0 after reset.

## Test plan
- Single read: after reset, `dmem` word 3 = 32'h02040206. Port 0 reads addr 3 → `ack0` in cycle N+2, `rd0` = 32'h02040206, `ack1` never asserts.
- Write then read: port 1 writes 32'hDEADBEEF to addr 5 → `rd1` on that ack = old value 32'h04060506. A following port 1 read of addr 5 returns 32'hDEADBEEF.
- Contention: `req0` and `req1` held continuously, each re-requesting after its ack, for 8 accesses → grant order 0,1,0,1,0,1,0,1 and each access takes exactly 3 cycles.
- Lock: port 0 issues a read with `lock0` = 1 while `req1` is pending, then a write with `lock0` = 0 → both port 0 accesses complete before port 1's first ack, and port 1 is served immediately after.
- Reset mid-write: assert `rst` during ACCESS of a port 0 write of 32'h11111111 to addr 0 → memory addr 0 = 32'h11111111, no `ack0`, all outputs at reset values on the next cycle.
- Back-to-back protocol: port 0 keeps `req0` high for one cycle past its ack → a second, distinct access is performed and `ack0` pulses again 3 cycles after the first.
